// File: rtl/ysyx_23060075_mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060075_mem_arb_pkg
// Shared definitions for the memory request arbiter:
//   - access size encodings carried on req_size
//   - FSM state encodings of the arbiter top
//   - byte-mask width derivation from the data width
//   - alignment check applied to every accepted request
// ---------------------------------------------------------------------------
package ysyx_23060075_mem_arb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    function automatic int mask_width(input int isa_width);
        return isa_width / 8;
    endfunction

    // 1 when the access cannot be issued: misaligned half/word or illegal size
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return |addr_lo;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060075_mem_arb_if.sv
// ---------------------------------------------------------------------------
// ysyx_23060075_mem_arb_if
// Bundles the requester channels, the shared downstream memory port and the
// error counter of the arbiter.
//   req_*   : per-channel request, channel i in slice i
//   resp_*  : one-hot response pulse with shared read data / error flag
//   mem_*   : single downstream port, mem_rvalid completes reads and writes
//   err_cnt : saturating count of error responses
// Modports: slave = the arbiter, master = the core/memory environment.
// ---------------------------------------------------------------------------
interface ysyx_23060075_mem_arb_if #(
    parameter int ISA_WIDTH     = 32,
    parameter int MASK_WIDTH    = ISA_WIDTH / 8,
    parameter int N_CH          = 2,
    parameter int ERR_CNT_WIDTH = 16
);
    logic [N_CH-1:0]            req_valid;
    logic [N_CH-1:0]            req_ready;
    logic [N_CH*ISA_WIDTH-1:0]  req_addr;
    logic [N_CH*ISA_WIDTH-1:0]  req_wdata;
    logic [N_CH*MASK_WIDTH-1:0] req_mask;
    logic [N_CH-1:0]            req_wen;
    logic [N_CH*2-1:0]          req_size;
    logic [N_CH-1:0]            resp_valid;
    logic [ISA_WIDTH-1:0]       resp_rdata;
    logic                       resp_err;
    logic                       mem_valid;
    logic                       mem_ready;
    logic [ISA_WIDTH-1:0]       mem_addr;
    logic [ISA_WIDTH-1:0]       mem_wdata;
    logic [MASK_WIDTH-1:0]      mem_mask;
    logic                       mem_wen;
    logic                       mem_rvalid;
    logic [ISA_WIDTH-1:0]       mem_rdata;
    logic [ERR_CNT_WIDTH-1:0]   err_cnt;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_mask, req_wen, req_size,
        input  mem_ready, mem_rvalid, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_valid, mem_addr, mem_wdata, mem_mask, mem_wen, err_cnt
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_mask, req_wen, req_size,
        output mem_ready, mem_rvalid, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_valid, mem_addr, mem_wdata, mem_mask, mem_wen, err_cnt
    );
endinterface

// File: rtl/ysyx_23060075_rr_arb.sv
// ---------------------------------------------------------------------------
// ysyx_23060075_rr_arb
// N-way grant logic. Search starts at the priority pointer and wraps; the
// first valid requester wins. With RR_EN=1 the pointer moves to granted+1
// on every accepted grant, with RR_EN=0 it stays at 0 (lowest index wins).
// Ports:
//   clk, rst  : clock, async active-low reset (pointer -> 0)
//   req       : request vector
//   advance   : grant was accepted this cycle
//   grant     : one-hot grant, zero when no request
//   grant_idx : binary index of the granted channel
// ---------------------------------------------------------------------------
module ysyx_23060075_rr_arb #(
    parameter int N_CH  = 2,
    parameter int RR_EN = 1,
    localparam int IDX_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  req,
    input  logic             advance,
    output logic [N_CH-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx
);
    logic [IDX_W-1:0] ptr;

    always_comb begin : pick
        int   j;
        logic found;
        j         = 0;
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        for (int k = 0; k < N_CH; k++) begin
            j = int'(ptr) + k;
            if (j >= N_CH) j = j - N_CH;
            if (!found && req[j[IDX_W-1:0]]) begin
                grant[j[IDX_W-1:0]] = 1'b1;
                grant_idx           = j[IDX_W-1:0];
                found               = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (RR_EN != 0 && advance) begin
            ptr <= (grant_idx == IDX_W'(N_CH - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end
endmodule

// File: rtl/ysyx_23060075_mem_arb.sv
// ---------------------------------------------------------------------------
// ysyx_23060075_mem_arb
// Arbitrates N_CH requesters onto one memory port, one transaction at a
// time, and answers misaligned / illegal-size requests locally with an
// error response instead of issuing them downstream.
// Ports:
//   clk, rst : clock, async active-low reset
//   bus      : slave side of ysyx_23060075_mem_arb_if (requests, responses,
//              downstream memory port, error counter)
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | grant shown on req_ready, waiting for a handshake
// REQ     | mem_valid high with latched fields, waiting for mem_ready
// WAIT    | request taken downstream, waiting for mem_rvalid
// ERR     | error response is on the outputs, no downstream access
// ---------------------------------------------------------------------------
module ysyx_23060075_mem_arb
    import ysyx_23060075_mem_arb_pkg::*;
#(
    parameter int ISA_WIDTH     = 32,
    parameter int MASK_WIDTH    = mask_width(ISA_WIDTH),
    parameter int N_CH          = 2,
    parameter int RR_EN         = 1,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    ysyx_23060075_mem_arb_if.slave    bus
);
    localparam int IDX_W = $clog2(N_CH);

    logic [1:0]               state;
    logic [IDX_W-1:0]         ch;
    logic [IDX_W-1:0]         grant_idx;
    logic [N_CH-1:0]          grant;
    logic                     accept;
    logic [ISA_WIDTH-1:0]     sel_addr;
    logic [ISA_WIDTH-1:0]     sel_wdata;
    logic [MASK_WIDTH-1:0]    sel_mask;
    logic [1:0]               sel_size;
    logic                     sel_wen;
    logic                     sel_err;

    logic                     mem_valid_q;
    logic [ISA_WIDTH-1:0]     mem_addr_q;
    logic [ISA_WIDTH-1:0]     mem_wdata_q;
    logic [MASK_WIDTH-1:0]    mem_mask_q;
    logic                     mem_wen_q;
    logic [N_CH-1:0]          resp_valid_q;
    logic [ISA_WIDTH-1:0]     resp_rdata_q;
    logic                     resp_err_q;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

    ysyx_23060075_rr_arb #(.N_CH(N_CH), .RR_EN(RR_EN)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // grant only contains valid channels, so any grant in IDLE is a handshake
    assign accept    = (state == ST_IDLE) && (|grant);
    assign sel_addr  = bus.req_addr [int'(grant_idx)*ISA_WIDTH  +: ISA_WIDTH];
    assign sel_wdata = bus.req_wdata[int'(grant_idx)*ISA_WIDTH  +: ISA_WIDTH];
    assign sel_mask  = bus.req_mask [int'(grant_idx)*MASK_WIDTH +: MASK_WIDTH];
    assign sel_size  = bus.req_size [int'(grant_idx)*2 +: 2];
    assign sel_wen   = bus.req_wen[grant_idx];
    assign sel_err   = misaligned(sel_size, sel_addr[1:0]);

    // gated by rst so req_ready reads zero for the whole reset window
    assign bus.req_ready  = (state == ST_IDLE && rst) ? grant : '0;
    assign bus.mem_valid  = mem_valid_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_mask   = mem_mask_q;
    assign bus.mem_wen    = mem_wen_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.err_cnt    = err_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            ch           <= '0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_mask_q   <= '0;
            mem_wen_q    <= 1'b0;
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            resp_valid_q <= '0;
            resp_err_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        ch <= grant_idx;
                        if (sel_err) begin
                            // response is registered here so it is visible during ERR
                            state        <= ST_ERR;
                            resp_valid_q <= grant;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
                        end else begin
                            state       <= ST_REQ;
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= sel_addr;
                            mem_wdata_q <= sel_wdata;
                            mem_mask_q  <= sel_mask;
                            mem_wen_q   <= sel_wen;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.mem_ready) begin
                        mem_valid_q <= 1'b0;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.mem_rvalid) begin
                        resp_valid_q <= N_CH'(1) << ch;
                        resp_rdata_q <= bus.mem_rdata;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_23060075_mem_arb.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060075_mem_arb
// Self-checking bench: table of request vectors driven through a 2-channel
// round-robin arbiter with a scoreboard of expected responses / downstream
// transactions, plus sequences for stall, rotation (4-channel RR and fixed
// instances) and reset in the middle of a transaction.
// ---------------------------------------------------------------------------
module tb_ysyx_23060075_mem_arb;
    import ysyx_23060075_mem_arb_pkg::*;

    typedef struct {
        int          ch;
        logic        wen;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        logic [1:0]  valid;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic        wen;
    } mem_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    last_resp_cyc = 0;
    int    err_exp = 0;
    bit    auto_rvalid = 1'b1;
    logic [31:0] mem_rdata_nx = '0;
    resp_t resp_q[$];
    mem_t  mem_q[$];

    ysyx_23060075_mem_arb_if #(.ISA_WIDTH(32), .MASK_WIDTH(4), .N_CH(2), .ERR_CNT_WIDTH(16)) bus ();
    ysyx_23060075_mem_arb_if #(.ISA_WIDTH(32), .MASK_WIDTH(4), .N_CH(4), .ERR_CNT_WIDTH(16)) b4r ();
    ysyx_23060075_mem_arb_if #(.ISA_WIDTH(32), .MASK_WIDTH(4), .N_CH(4), .ERR_CNT_WIDTH(16)) b4f ();

    ysyx_23060075_mem_arb #(.ISA_WIDTH(32), .MASK_WIDTH(4), .N_CH(2), .RR_EN(1), .ERR_CNT_WIDTH(16))
        dut (.clk(clk), .rst(rst), .bus(bus.slave));
    ysyx_23060075_mem_arb #(.ISA_WIDTH(32), .MASK_WIDTH(4), .N_CH(4), .RR_EN(1), .ERR_CNT_WIDTH(16))
        dut4r (.clk(clk), .rst(rst), .bus(b4r.slave));
    ysyx_23060075_mem_arb #(.ISA_WIDTH(32), .MASK_WIDTH(4), .N_CH(4), .RR_EN(0), .ERR_CNT_WIDTH(16))
        dut4f (.clk(clk), .rst(rst), .bus(b4f.slave));

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // downstream model: completes one cycle after the mem_valid/mem_ready handshake
    initial begin : responder
        bit hs;
        forever begin
            @(negedge clk);
            hs = bus.mem_valid && bus.mem_ready;
            @(posedge clk);
            #1;
            if (auto_rvalid) begin
                bus.mem_rvalid = hs;
                bus.mem_rdata  = hs ? mem_rdata_nx : 32'h0;
            end
        end
    end

    initial begin : monitor
        resp_t r;
        mem_t  m;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bus.resp_valid != 2'b00) begin
                    last_resp_cyc = cyc;
                    if (resp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL resp_unexpected: got resp_valid %b expected none", bus.resp_valid);
                    end else begin
                        r = resp_q.pop_front();
                        chk("resp_valid", bus.resp_valid, r.valid);
                        chk("resp_err",   bus.resp_err,   r.err);
                        chk("resp_rdata", bus.resp_rdata, r.rdata);
                    end
                end
                if (bus.mem_valid && bus.mem_ready) begin
                    if (mem_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mem_unexpected: got mem_addr 0x%0h expected none", bus.mem_addr);
                    end else begin
                        m = mem_q.pop_front();
                        chk("mem_addr",  bus.mem_addr,  m.addr);
                        chk("mem_wdata", bus.mem_wdata, m.wdata);
                        chk("mem_mask",  bus.mem_mask,  m.mask);
                        chk("mem_wen",   bus.mem_wen,   m.wen);
                    end
                end
            end
        end
    end

    task automatic drive_req(input vec_t v);
        bus.req_valid                   = 2'b00;
        bus.req_valid[v.ch]             = 1'b1;
        bus.req_addr [v.ch*32 +: 32]    = v.addr;
        bus.req_wdata[v.ch*32 +: 32]    = v.wdata;
        bus.req_mask [v.ch*4 +: 4]      = v.mask;
        bus.req_size [v.ch*2 +: 2]      = v.size;
        bus.req_wen  [v.ch]             = v.wen;
        mem_rdata_nx                    = v.rdata;
    endtask

    task automatic push_exp(input vec_t v, input bit with_resp);
        resp_t r;
        mem_t  m;
        r.valid = 2'b01 << v.ch;
        r.err   = v.err;
        r.rdata = v.err ? 32'h0 : v.rdata;
        if (with_resp) resp_q.push_back(r);
        if (!v.err) begin
            m.addr  = v.addr;
            m.wdata = v.wdata;
            m.mask  = v.mask;
            m.wen   = v.wen;
            mem_q.push_back(m);
        end
        if (v.err) err_exp++;
    endtask

    task automatic wait_accept(input int ch, output int t);
        t = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req_ready[ch]) begin
                t = cyc;
                chk("req_ready_grant", bus.req_ready, 2'b01 << ch);
                break;
            end
        end
        if (t < 0) fail("accept_timeout");
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (resp_q.size() == 0 && mem_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!done) fail("drain_timeout");
    endtask

    task automatic run_vec(input vec_t v);
        int t;
        @(posedge clk);
        #1;
        drive_req(v);
        push_exp(v, 1'b1);
        wait_accept(v.ch, t);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        drain();
        chk("latency", last_resp_cyc - t, v.err ? 1 : 3);
        chk("err_cnt", bus.err_cnt, err_exp);
    endtask

    function automatic int idx_of(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) if (oh[i]) return i;
        return -1;
    endfunction

    initial begin : main
        vec_t vt[8];
        vec_t v;
        int   t, t1;
        int   gr[5], gf[5];
        int   nr, nf;

        vt[0] = '{1, 1'b0, SZ_WORD, 32'h8000_0004, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0};
        vt[1] = '{0, 1'b0, SZ_HALF, 32'h8000_0001, 32'h0,         4'h3, 32'h0,         1'b1};
        vt[2] = '{1, 1'b1, SZ_HALF, 32'h8000_0002, 32'h1234_5678, 4'h3, 32'h0,         1'b0};
        vt[3] = '{0, 1'b0, SZ_BYTE, 32'h8000_0003, 32'h0,         4'h1, 32'h0000_00AB, 1'b0};
        vt[4] = '{0, 1'b0, SZ_ILL,  32'h8000_0000, 32'h0,         4'hF, 32'h0,         1'b1};
        vt[5] = '{1, 1'b0, SZ_WORD, 32'h8000_0008, 32'h0,         4'hF, 32'h0BAD_F00D, 1'b0};
        vt[6] = '{1, 1'b0, SZ_WORD, 32'h8000_0006, 32'h0,         4'hF, 32'h0,         1'b1};
        vt[7] = '{0, 1'b0, SZ_HALF, 32'h8000_0006, 32'h0,         4'h3, 32'h0000_5555, 1'b0};

        bus.req_valid = 2'b11;
        bus.req_addr = '0; bus.req_wdata = '0; bus.req_mask = '0; bus.req_wen = '1; bus.req_size = '0;
        bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        b4r.req_valid = '0; b4r.req_addr = '0; b4r.req_wdata = '0; b4r.req_mask = '0;
        b4r.req_wen = '0; b4r.req_size = '1;
        b4r.mem_ready = 1'b1; b4r.mem_rvalid = 1'b0; b4r.mem_rdata = '0;
        b4f.req_valid = '0; b4f.req_addr = '0; b4f.req_wdata = '0; b4f.req_mask = '0;
        b4f.req_wen = '0; b4f.req_size = '1;
        b4f.mem_ready = 1'b1; b4f.mem_rvalid = 1'b0; b4f.mem_rdata = '0;

        // reset values, with requests pending so req_ready=0 means something
        repeat (2) @(negedge clk);
        chk("rst_req_ready",  bus.req_ready,  2'b00);
        chk("rst_resp_valid", bus.resp_valid, 2'b00);
        chk("rst_mem_valid",  bus.mem_valid,  1'b0);
        chk("rst_mem_wen",    bus.mem_wen,    1'b0);
        chk("rst_mem_addr",   bus.mem_addr,   32'h0);
        chk("rst_resp_err",   bus.resp_err,   1'b0);
        chk("rst_err_cnt",    bus.err_cnt,    16'h0);
        bus.req_valid = 2'b00;
        bus.req_wen = '0;
        rst = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vt[i]);

        // downstream stall: fields held, no new grant while busy
        bus.mem_ready = 1'b0;
        v = '{0, 1'b1, SZ_WORD, 32'h8000_0010, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0};
        @(posedge clk);
        #1;
        drive_req(v);
        push_exp(v, 1'b1);
        wait_accept(0, t);
        @(posedge clk);
        #1;
        v = '{1, 1'b0, SZ_ILL, 32'h8000_0020, 32'h0, 4'hF, 32'h0, 1'b1};
        drive_req(v);
        push_exp(v, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_mem_valid", bus.mem_valid, 1'b1);
            chk("stall_mem_addr",  bus.mem_addr,  32'h8000_0010);
            chk("stall_mem_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
            chk("stall_mem_mask",  bus.mem_mask,  4'hF);
            chk("stall_mem_wen",   bus.mem_wen,   1'b1);
            chk("stall_req_ready", bus.req_ready, 2'b00);
        end
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        wait_accept(1, t1);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        drain();
        chk("stall_err_latency", last_resp_cyc - t1, 1);
        chk("stall_err_cnt", bus.err_cnt, err_exp);

        // four channels all valid: RR rotates, fixed priority sticks to 0
        @(posedge clk);
        #1;
        b4r.req_valid = 4'hF;
        b4f.req_valid = 4'hF;
        nr = 0;
        nf = 0;
        for (int i = 0; i < 40 && (nr < 5 || nf < 5); i++) begin
            @(negedge clk);
            chk("rr4_mem_valid", b4r.mem_valid, 1'b0);
            if (b4r.req_ready != 4'h0 && nr < 5) begin gr[nr] = idx_of(b4r.req_ready); nr++; end
            if (b4f.req_ready != 4'h0 && nf < 5) begin gf[nf] = idx_of(b4f.req_ready); nf++; end
        end
        if (nr < 5 || nf < 5) fail("rotation_timeout");
        for (int k = 0; k < 5; k++) begin
            if (k < nr) chk("rr_grant_order", gr[k], k % 4);
            if (k < nf) chk("fixed_grant",    gf[k], 0);
        end
        @(posedge clk);
        #1;
        b4r.req_valid = 4'h0;
        b4f.req_valid = 4'h0;

        // reset during WAIT: outputs clear at once, late mem_rvalid is ignored
        auto_rvalid = 1'b0;
        bus.mem_rvalid = 1'b0;
        v = '{0, 1'b1, SZ_WORD, 32'h8000_0040, 32'hCAFE_0001, 4'hF, 32'h0, 1'b0};
        @(posedge clk);
        #1;
        drive_req(v);
        push_exp(v, 1'b0);
        wait_accept(0, t);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        @(posedge clk);
        #1;
        bus.req_valid = 2'b11;
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_req_ready",  bus.req_ready,  2'b00);
        chk("mid_rst_resp_valid", bus.resp_valid, 2'b00);
        chk("mid_rst_mem_valid",  bus.mem_valid,  1'b0);
        chk("mid_rst_mem_addr",   bus.mem_addr,   32'h0);
        chk("mid_rst_mem_wdata",  bus.mem_wdata,  32'h0);
        chk("mid_rst_mem_mask",   bus.mem_mask,   4'h0);
        chk("mid_rst_mem_wen",    bus.mem_wen,    1'b0);
        chk("mid_rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("mid_rst_resp_err",   bus.resp_err,   1'b0);
        chk("mid_rst_err_cnt",    bus.err_cnt,    16'h0);
        @(negedge clk);
        bus.req_valid = 2'b00;
        rst = 1'b1;
        err_exp = 0;
        @(posedge clk);
        #1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hFFFF_0000;
        @(posedge clk);
        #1;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("late_rvalid_ignored", bus.resp_valid, 2'b00);
        end
        auto_rvalid = 1'b1;

        run_vec(vt[0]);
        run_vec(vt[1]);
        chk("resp_q_empty", resp_q.size(), 0);
        chk("mem_q_empty",  mem_q.size(),  0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1);
    end
endmodule
